// File: rtl/memory_unit_arb.sv
// Multi-channel NockPU memory unit: single-port synchronous RAM plus a saturating bump
// allocator, shared by NUM_CH requesters through a round-robin arbiter.
module memory_unit_arb #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 68,
  parameter int ADDR_W     = 10,
  parameter int FREE_BASE  = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [2*NUM_CH-1:0]      ch_func,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_err,
  output logic                     is_ready,
  output logic [ADDR_W:0]          free_count
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0] F_GET = 2'b00, F_SET = 2'b01, F_FREE = 2'b10, F_ALLOC = 2'b11;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_EXEC, S_READ_WAIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_ctr;
  logic [ADDR_W:0]     free_ptr;
  logic [CH_W-1:0]     rr_last, grant, grant_nxt;
  logic                any_req, full;
  logic [1:0]          op_func, sel_func;
  logic [ADDR_W-1:0]   op_addr, sel_addr;
  logic [DATA_W-1:0]   op_wdata, sel_wdata;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, ram_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign full       = (free_ptr == DEPTH_V);
  assign free_count = DEPTH_V - free_ptr;
  assign is_ready   = (state == S_IDLE);

  // Lowest requester above rr_last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    any_req   = |ch_req;
    grant_nxt = '0;
    sel_func  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (ch_req[i]) grant_nxt = CH_W'(i);
    end
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (ch_req[i] && (i > int'(rr_last))) grant_nxt = CH_W'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == grant_nxt) begin
        sel_func  = ch_func[2*i +: 2];
        sel_addr  = ch_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = ch_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:      if ((INIT_CLEAR == 0) || (init_ctr == ADDR_W'(DEPTH-1))) state_nxt = S_IDLE;
      S_IDLE:      if (any_req) state_nxt = S_EXEC;
      S_EXEC:      state_nxt = (op_func == F_GET) ? S_READ_WAIT : S_DONE;
      S_READ_WAIT: state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    ch_done = '0;
    if (state == S_DONE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_W'(i) == grant) ch_done[i] = 1'b1;
      end
    end
  end

  // The single RAM port is shared by init clearing, SET writes, ALLOC_SET writes and reads.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = op_addr;
    mem_wdata = op_wdata;
    if (!rst) begin
      case (state)
        S_INIT: begin
          if (INIT_CLEAR != 0) begin
            mem_we    = 1'b1;
            mem_addr  = init_ctr;
            mem_wdata = '0;
          end
        end
        S_EXEC: begin
          if (op_func == F_SET) begin
            mem_we = 1'b1;
          end else if ((op_func == F_ALLOC) && !full) begin
            mem_we   = 1'b1;
            mem_addr = free_ptr[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    ram_q <= mem[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_ctr <= '0;
      free_ptr <= (ADDR_W+1)'(FREE_BASE);
      rr_last  <= CH_W'(NUM_CH-1);
      grant    <= '0;
      op_func  <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      rsp_data <= '0;
      rsp_addr <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_INIT: init_ctr <= init_ctr + 1'b1;
        S_IDLE: begin
          if (any_req) begin
            grant    <= grant_nxt;
            rr_last  <= grant_nxt;
            op_func  <= sel_func;
            op_addr  <= sel_addr;
            op_wdata <= sel_wdata;
          end
        end
        S_EXEC: begin
          if (op_func == F_SET) begin
            rsp_data <= '0;
            rsp_addr <= op_addr;
            rsp_err  <= 1'b0;
          end else if (op_func != F_GET) begin
            rsp_data <= '0;
            if (full) begin
              rsp_err  <= 1'b1;
              rsp_addr <= '0;
            end else begin
              rsp_err  <= 1'b0;
              rsp_addr <= free_ptr[ADDR_W-1:0];
              free_ptr <= free_ptr + 1'b1;
            end
          end
        end
        // Read results are published only here so all rsp fields change together.
        S_READ_WAIT: begin
          rsp_data <= ram_q;
          rsp_addr <= op_addr;
          rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_unit_arb.sv
// Directed bench for memory_unit_arb: a 3-channel cleared instance driven from a vector
// table, and a 2-channel preloaded instance for reset-during-read behaviour.
module tb_memory_unit_arb;

  localparam int NC = 3, NC1 = 2, DW = 68, AW = 4;
  localparam logic [1:0] GET = 2'b00, SET = 2'b01, FREE = 2'b10, ALLOC = 2'b11;
  localparam logic [DW-1:0] BEEF = 68'hDEADBEEF;
  localparam logic [DW-1:0] HI   = 68'h8_0000_0000_0000_0001;

  typedef struct {
    int              ch;
    logic [1:0]      func;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   exp_data;
    logic [AW-1:0]   exp_addr;
    logic            exp_err;
    logic [AW:0]     exp_fc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NC-1:0]     ch_req;
  logic [2*NC-1:0]   ch_func;
  logic [AW*NC-1:0]  ch_addr;
  logic [DW*NC-1:0]  ch_wdata;
  logic [NC-1:0]     ch_done;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     rsp_addr;
  logic              rsp_err, is_ready;
  logic [AW:0]       free_count;

  logic              rst1;
  logic [NC1-1:0]    ch_req1;
  logic [2*NC1-1:0]  ch_func1;
  logic [AW*NC1-1:0] ch_addr1;
  logic [DW*NC1-1:0] ch_wdata1;
  logic [NC1-1:0]    ch_done1;
  logic [DW-1:0]     rsp_data1;
  logic [AW-1:0]     rsp_addr1;
  logic              rsp_err1, is_ready1;
  logic [AW:0]       free_count1;

  memory_unit_arb #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .FREE_BASE(0), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_func(ch_func), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_done(ch_done), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .is_ready(is_ready), .free_count(free_count));

  memory_unit_arb #(.NUM_CH(NC1), .DATA_W(DW), .ADDR_W(AW), .FREE_BASE(3), .INIT_CLEAR(0)) dut1 (
    .clk(clk), .rst(rst1), .ch_req(ch_req1), .ch_func(ch_func1), .ch_addr(ch_addr1),
    .ch_wdata(ch_wdata1), .ch_done(ch_done1), .rsp_data(rsp_data1), .rsp_addr(rsp_addr1),
    .rsp_err(rsp_err1), .is_ready(is_ready1), .free_count(free_count1));

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int ch, logic [1:0] func, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                               logic [DW-1:0] ed, logic [AW-1:0] ea, logic ee, logic [AW:0] efc);
    vec_t v;
    v.ch = ch; v.func = func; v.addr = addr; v.wdata = wdata;
    v.exp_data = ed; v.exp_addr = ea; v.exp_err = ee; v.exp_fc = efc;
    return v;
  endfunction

  // Drives one request on dut, waits (bounded) for ch_done, then checks the pulse ends.
  task automatic applyStimulus(input int ch, input logic [1:0] func, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, output int lat,
                               output logic [NC-1:0] done_seen, output logic pulse_low);
    @(negedge clk);
    ch_req[ch] = 1'b1;
    ch_func[2*ch +: 2] = func;
    ch_addr[AW*ch +: AW] = addr;
    ch_wdata[DW*ch +: DW] = wdata;
    lat = 0;
    done_seen = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ch_done != '0) begin
        lat = n;
        done_seen = ch_done;
        break;
      end
    end
    @(negedge clk);
    ch_req[ch] = 1'b0;
    @(posedge clk); #1;
    pulse_low = (ch_done == '0);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    int lat;
    logic [NC-1:0] ds, ed;
    logic pl;
    applyStimulus(v.ch, v.func, v.addr, v.wdata, lat, ds, pl);
    ed = '0;
    ed[v.ch] = 1'b1;
    checkOutput({tag, "_done"}, 72'(ds), 72'(ed));
    checkOutput({tag, "_latency"}, 72'(lat), (v.func == GET) ? 72'd3 : 72'd2);
    checkOutput({tag, "_pulse_end"}, 72'(pl), 72'd1);
    checkOutput({tag, "_rsp_data"}, 72'(rsp_data), 72'(v.exp_data));
    checkOutput({tag, "_rsp_addr"}, 72'(rsp_addr), 72'(v.exp_addr));
    checkOutput({tag, "_rsp_err"}, 72'(rsp_err), 72'(v.exp_err));
    checkOutput({tag, "_free_count"}, 72'(free_count), 72'(v.exp_fc));
  endtask

  task automatic releaseAndCount(input int exp, input string name);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    while (!is_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 72'(n), 72'(exp));
  endtask

  task automatic op1(input int ch, input logic [1:0] func, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, output logic [NC1-1:0] done_seen);
    @(negedge clk);
    ch_req1[ch] = 1'b1;
    ch_func1[2*ch +: 2] = func;
    ch_addr1[AW*ch +: AW] = addr;
    ch_wdata1[DW*ch +: DW] = wdata;
    done_seen = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ch_done1 != '0) begin
        done_seen = ch_done1;
        break;
      end
    end
    @(negedge clk);
    ch_req1[ch] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, n;
    logic [NC-1:0] ds;
    logic [NC1-1:0] ds1;
    logic pl;

    rst = 1'b1; ch_req = '0; ch_func = '0; ch_addr = '0; ch_wdata = '0;
    rst1 = 1'b1; ch_req1 = '0; ch_func1 = '0; ch_addr1 = '0; ch_wdata1 = '0;

    vecs.push_back(mkv(0, FREE,  0, 0,    0,    0,  0, 15));
    vecs.push_back(mkv(0, FREE,  0, 0,    0,    1,  0, 14));
    vecs.push_back(mkv(0, SET,   1, BEEF, 0,    1,  0, 14));
    vecs.push_back(mkv(0, GET,   1, 0,    BEEF, 1,  0, 14));
    vecs.push_back(mkv(1, ALLOC, 0, 4,    0,    2,  0, 13));
    vecs.push_back(mkv(2, GET,   2, 0,    4,    2,  0, 13));
    vecs.push_back(mkv(1, SET,  15, HI,   0,    15, 0, 13));
    vecs.push_back(mkv(0, GET,  15, 0,    HI,   15, 0, 13));
    vecs.push_back(mkv(2, FREE,  0, 0,    0,    3,  0, 12));
    for (int a = 4; a <= 14; a++)
      vecs.push_back(mkv(a % 3, FREE, 0, 0, 0, 4'(a), 0, 5'(15 - a)));
    vecs.push_back(mkv(1, ALLOC, 0, 68'h77, 0,      15, 0, 0));
    vecs.push_back(mkv(0, FREE,  9, 0,      0,      0,  1, 0));
    vecs.push_back(mkv(2, ALLOC, 0, 68'h99, 0,      0,  1, 0));
    vecs.push_back(mkv(0, GET,   0, 0,      0,      0,  0, 0));
    vecs.push_back(mkv(1, GET,  15, 0,      68'h77, 15, 0, 0));
    vecs.push_back(mkv(2, GET,   1, 0,      BEEF,   1,  0, 0));

    $display("[TB] reset and init clearing");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_is_ready", 72'(is_ready), 72'd0);
    checkOutput("reset_ch_done", 72'(ch_done), 72'd0);
    checkOutput("reset_rsp_data", 72'(rsp_data), 72'd0);
    checkOutput("reset_rsp_addr", 72'(rsp_addr), 72'd0);
    checkOutput("reset_rsp_err", 72'(rsp_err), 72'd0);
    checkOutput("reset_free_count", 72'(free_count), 72'd16);
    releaseAndCount(16, "init_cycles");

    for (int a = 0; a < 16; a++) begin
      applyStimulus(a % NC, GET, 4'(a), 0, lat, ds, pl);
      checkOutput($sformatf("clear_read%0d", a), 72'(rsp_data), 72'd0);
    end

    $display("[TB] vector table");
    foreach (vecs[k]) runVec(vecs[k], $sformatf("v%0d", k));

    $display("[TB] request fields sampled only at grant");
    @(negedge clk);
    ch_req[1] = 1'b1; ch_func[3:2] = GET; ch_addr[7:4] = 4'd1; ch_wdata[DW +: DW] = '0;
    @(posedge clk);
    @(negedge clk);
    ch_func[3:2] = SET; ch_addr[7:4] = 4'd15; ch_wdata[DW +: DW] = 68'h55;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ch_done != '0) begin lat = k; break; end
    end
    checkOutput("latch_latency", 72'(lat), 72'd3);
    checkOutput("latch_rsp_data", 72'(rsp_data), 72'(BEEF));
    checkOutput("latch_rsp_addr", 72'(rsp_addr), 72'd1);
    @(negedge clk);
    ch_req[1] = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, GET, 15, 0, lat, ds, pl);
    checkOutput("latch_no_write", 72'(rsp_data), 72'h77);

    $display("[TB] round robin with three continuous requesters");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    releaseAndCount(16, "rr_init_cycles");
    @(negedge clk);
    ch_func = {SET, SET, SET};
    ch_addr = {4'd7, 4'd6, 4'd5};
    ch_wdata = {68'hA2, 68'hA1, 68'hA0};
    ch_req = '1;
    for (int op = 0; op < 6; op++) begin
      ds = '0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (ch_done != '0) begin ds = ch_done; break; end
      end
      checkOutput($sformatf("rr_grant%0d", op), 72'(ds), 72'(1 << (op % 3)));
      checkOutput($sformatf("rr_addr%0d", op), 72'(rsp_addr), 72'(5 + op % 3));
      if (op == 5) begin
        @(negedge clk);
        ch_req = '0;
      end
      @(posedge clk); #1;
      checkOutput($sformatf("rr_pulse%0d", op), 72'(ch_done), 72'd0);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(c, GET, 4'(5 + c), 0, lat, ds, pl);
      checkOutput($sformatf("rr_read%0d", c), 72'(rsp_data), 72'(8'hA0 + c));
    end

    $display("[TB] reset during READ_WAIT");
    applyStimulus(0, FREE, 0, 0, lat, ds, pl);
    checkOutput("mid_pre_free_count", 72'(free_count), 72'd15);
    @(negedge clk);
    ch_req[0] = 1'b1; ch_func[1:0] = GET; ch_addr[3:0] = 4'd5;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("mid_no_done_read_wait", 72'(ch_done), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    ch_req = '0;
    @(posedge clk); #1;
    checkOutput("mid_no_done_reset", 72'(ch_done), 72'd0);
    checkOutput("mid_is_ready", 72'(is_ready), 72'd0);
    checkOutput("mid_free_count", 72'(free_count), 72'd16);
    checkOutput("mid_rsp_addr", 72'(rsp_addr), 72'd0);
    releaseAndCount(16, "mid_init_cycles");
    applyStimulus(2, FREE, 0, 0, lat, ds, pl);
    checkOutput("mid_rewound_addr", 72'(rsp_addr), 72'd0);
    checkOutput("mid_rewound_done", 72'(ds), 72'b100);

    $display("[TB] preloaded instance without clearing");
    @(posedge clk); #1;
    checkOutput("pre_reset_ready", 72'(is_ready1), 72'd0);
    checkOutput("pre_reset_free_count", 72'(free_count1), 72'd13);
    @(negedge clk);
    rst1 = 1'b0;
    n = 0;
    while (!is_ready1 && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("pre_init_cycles", 72'(n), 72'd1);
    op1(1, SET, 4, 68'h1234, ds1);
    checkOutput("pre_set_done", 72'(ds1), 72'b10);
    op1(0, FREE, 0, 0, ds1);
    checkOutput("pre_free_addr", 72'(rsp_addr1), 72'd3);
    checkOutput("pre_free_count", 72'(free_count1), 72'd12);
    @(negedge clk);
    ch_req1[0] = 1'b1; ch_func1[1:0] = GET; ch_addr1[3:0] = 4'd4;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b1;
    ch_req1 = '0;
    @(posedge clk); #1;
    checkOutput("pre_mid_no_done", 72'(ch_done1), 72'd0);
    checkOutput("pre_mid_ready", 72'(is_ready1), 72'd0);
    checkOutput("pre_mid_free_count", 72'(free_count1), 72'd13);
    @(negedge clk);
    rst1 = 1'b0;
    n = 0;
    while (!is_ready1 && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("pre_mid_init_cycles", 72'(n), 72'd1);
    op1(1, GET, 4, 0, ds1);
    checkOutput("pre_preserved_data", 72'(rsp_data1), 72'h1234);
    op1(0, FREE, 0, 0, ds1);
    checkOutput("pre_rewound_addr", 72'(rsp_addr1), 72'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
